// File: rtl/flit_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one flit link among NUM_REQ requesters.
// A header flit wins arbitration, and that requester then owns the link (wormhole lock)
// until the last flit of its packet is accepted. The data path is purely combinational:
// flits pass straight through with no storage and no added latency.

package flit_tx_arbiter_pkg;

  typedef struct packed {
    logic [1:0]  vc;
    logic [3:0]  id;
    logic        req;
    logic [31:0] payload;
  } flit_t;

  localparam logic [3:0] FMT_LONG_READ   = 4'd0;
  localparam logic [3:0] FMT_LONG_WRITE  = 4'd1;
  localparam logic [3:0] FMT_MEM_RESP    = 4'd2;
  localparam logic [3:0] FMT_MSG         = 4'd3;
  localparam logic [3:0] FMT_SWITCH_CFG  = 4'd4;
  localparam logic [3:0] FMT_SHORT_READ  = 4'd5;
  localparam logic [3:0] FMT_SHORT_WRITE = 4'd6;

endpackage

module flit_tx_arbiter
  import flit_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  flit_t [NUM_REQ-1:0]       req_flit,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output flit_t                     out_flit,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [REQ_W-1:0]          grant_id,
  output logic                      pkt_done,
  output logic                      fmt_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [REQ_W-1:0] rr_ptr;
  logic [REQ_W-1:0] lock;
  logic [7:0]       remaining;

  logic [REQ_W-1:0] winner;
  logic             any_valid;
  logic [REQ_W-1:0] sel;
  logic             accept;
  logic [7:0]       hdr_cnt;

  // Total flits in a packet, header included. A zero length field encodes the
  // field's maximum (128 for the 7-bit field, 16 for the 4-bit one); the largest
  // packet is 130 flits, so 8 bits are enough.
  function automatic logic [7:0] flit_count(input logic [3:0] fmt, input logic [6:0] len7);
    logic [7:0] ext7;
    logic [7:0] ext4;
    ext7 = (len7 == 7'd0) ? 8'd128 : {1'b0, len7};
    ext4 = (len7[3:0] == 4'd0) ? 8'd16 : {4'd0, len7[3:0]};
    case (fmt)
      FMT_LONG_READ:   flit_count = 8'd2;
      FMT_LONG_WRITE:  flit_count = ext7 + 8'd2;
      FMT_MEM_RESP:    flit_count = ext7 + 8'd1;
      FMT_MSG:         flit_count = ext7 + 8'd1;
      FMT_SWITCH_CFG:  flit_count = 8'd1;
      FMT_SHORT_READ:  flit_count = 8'd1;
      FMT_SHORT_WRITE: flit_count = ext4 + 8'd1;
      default:         flit_count = 8'd1;
    endcase
  endfunction

  function automatic logic fmt_undefined(input logic [3:0] fmt);
    fmt_undefined = (fmt > FMT_SHORT_WRITE);
  endfunction

  // Round-robin successor; handles non-power-of-2 requester counts.
  function automatic logic [REQ_W-1:0] ptr_next(input logic [REQ_W-1:0] p);
    if (p == REQ_W'(NUM_REQ - 1)) ptr_next = '0;
    else                          ptr_next = p + 1'b1;
  endfunction

  // Pick the first valid requester starting at rr_ptr and wrapping around.
  always_comb begin
    winner    = rr_ptr;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int               idx;
      logic [REQ_W-1:0] cand;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = idx[REQ_W-1:0];
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Steer the owning requester onto the link and return ready only to it.
  always_comb begin
    sel       = (state == LOCKED) ? lock : winner;
    out_valid = (state == LOCKED) ? req_valid[lock] : any_valid;
    out_flit  = req_flit[sel];
    grant_id  = sel;
    req_ready = '0;
    if (state == LOCKED || any_valid) req_ready[sel] = out_ready;
    accept    = out_valid & out_ready;
    hdr_cnt   = flit_count(out_flit.payload[31:28], out_flit.payload[6:0]);
    busy      = (state == LOCKED);
  end

  // Arbitration / lock FSM with registered completion and format-error pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lock      <= '0;
      remaining <= '0;
      pkt_done  <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      fmt_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            fmt_err <= fmt_undefined(out_flit.payload[31:28]);
            if (hdr_cnt == 8'd1) begin
              pkt_done <= 1'b1;
              rr_ptr   <= ptr_next(winner);
            end else begin
              state     <= LOCKED;
              lock      <= winner;
              remaining <= hdr_cnt - 8'd1;
            end
          end
        end
        LOCKED: begin
          if (accept) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state    <= IDLE;
              rr_ptr   <= ptr_next(lock);
              pkt_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_tx_arbiter.sv
// Bench for flit_tx_arbiter: per-requester packet queues feed the DUT, a packet-level
// model predicts every output each cycle, and directed scenarios pin the model with
// hand-computed grant orders, flit counts and pulse counts.

module tb_flit_tx_arbiter;
  import flit_tx_arbiter_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  flit_t [N-1:0]  req_flit = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  flit_t          out_flit;
  logic           out_ready = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           pkt_done;
  logic           fmt_err;

  flit_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_flit(req_flit), .req_ready(req_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
    .busy(busy), .grant_id(grant_id), .pkt_done(pkt_done), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct { int src; flit_t f; } ent_t;

  int     checks = 0;
  int     errors = 0;
  flit_t  q [N][$];
  bit     hold [N];
  logic [N-1:0] acc_s = '0;
  ent_t   log_q [$];

  // packet-level model state
  int     m_owner = -1;
  int     m_left  = 0;
  int     m_rr    = 0;
  bit     m_pd    = 0;
  bit     m_fe    = 0;
  int     busy_cycles = 0;
  int     pd_pulses = 0;
  int     fe_pulses = 0;
  int     e_g;
  bit     e_v;
  logic [N-1:0] e_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pkt_len(input logic [31:0] p);
    int l7, l4;
    l7 = (p[6:0] == 7'd0) ? 128 : int'(p[6:0]);
    l4 = (p[3:0] == 4'd0) ? 16 : int'(p[3:0]);
    case (p[31:28])
      FMT_LONG_READ:   return 2;
      FMT_LONG_WRITE:  return 2 + l7;
      FMT_MEM_RESP:    return 1 + l7;
      FMT_MSG:         return 1 + l7;
      FMT_SHORT_WRITE: return 1 + l4;
      default:         return 1;
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (q[i].size() > 0) && !hold[i];
      req_flit[i]  = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  task automatic push_pkt(input int i, input logic [3:0] fmt, input logic [6:0] len);
    flit_t h;
    int    n;
    h.vc = 2'(i); h.id = 4'(i); h.req = 1'b1;
    h.payload = {fmt, 21'h0, len};
    n = pkt_len(h.payload);
    q[i].push_back(h);
    for (int k = 1; k < n; k++) begin
      flit_t b;
      b.vc = 2'(i); b.id = 4'(i); b.req = 1'b0;
      b.payload = {4'hA, 20'h0, 8'(k)};
      q[i].push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_s[i] && q[i].size() > 0) void'(q[i].pop_front());
    acc_s = '0;
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_until_empty(input int bound, input string name);
    int c;
    c = 0;
    while (!(all_empty() && m_owner < 0) && c < bound) begin
      tick();
      c++;
    end
    if (c >= bound) begin
      errors++;
      $display("FAIL %s_timeout: not drained after %0d cycles", name, bound);
    end
    tick();
  endtask

  // Compare the DUT against the packet model on every falling edge.
  always @(negedge clk) begin
    if (!n_rst) begin
      m_owner = -1; m_left = 0; m_rr = 0; m_pd = 0; m_fe = 0;
      acc_s = '0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pkt_done", 64'(pkt_done), 64'd0);
      chk("rst_fmt_err", 64'(fmt_err), 64'd0);
    end else begin
      chk("pkt_done", 64'(pkt_done), 64'(m_pd));
      chk("fmt_err", 64'(fmt_err), 64'(m_fe));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
      if (busy) busy_cycles++;
      if (pkt_done) pd_pulses++;
      if (fmt_err) fe_pulses++;

      e_rdy = '0;
      if (m_owner >= 0) begin
        e_g = m_owner;
        e_v = req_valid[m_owner];
        e_rdy[m_owner] = out_ready;
      end else begin
        e_v = 0;
        e_g = m_rr;
        for (int k = 0; k < N; k++) begin
          if (!e_v && req_valid[(m_rr + k) % N]) begin
            e_v = 1;
            e_g = (m_rr + k) % N;
          end
        end
        if (e_v) e_rdy[e_g] = out_ready;
      end

      chk("out_valid", 64'(out_valid), 64'(e_v));
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      if (e_v) begin
        chk("grant_id", 64'(grant_id), 64'(e_g));
        chk("out_flit", 64'(out_flit), 64'(req_flit[e_g]));
      end

      acc_s = req_valid & req_ready;
      m_pd = 0;
      m_fe = 0;
      if (e_v && out_ready) begin
        log_q.push_back('{src: e_g, f: req_flit[e_g]});
        if (m_owner < 0) begin
          int n;
          n = pkt_len(req_flit[e_g].payload);
          m_fe = (req_flit[e_g].payload[31:28] >= 4'd7);
          if (n == 1) begin
            m_pd = 1;
            m_rr = (e_g + 1) % N;
          end else begin
            m_owner = e_g;
            m_left  = n - 1;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_pd = 1;
            m_rr = (m_owner + 1) % N;
            m_owner = -1;
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) hold[i] = 0;

    // Reset with every requester valid; first grant after release goes to req0.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) push_pkt(i, FMT_SHORT_READ, 7'd0);
    push_pkt(0, FMT_SHORT_READ, 7'd0);
    drive();
    tick(); tick();
    chk("reset_busy_literal", 64'(busy), 64'd0);
    log_q.delete();
    pd_pulses = 0;
    n_rst = 1'b1;
    run_until_empty(50, "rotation");
    chk("rot_count", 64'(log_q.size()), 64'd5);
    if (log_q.size() == 5) begin
      chk("rot_g0", 64'(log_q[0].src), 64'd0);
      chk("rot_g1", 64'(log_q[1].src), 64'd1);
      chk("rot_g2", 64'(log_q[2].src), 64'd2);
      chk("rot_g3", 64'(log_q[3].src), 64'd3);
      chk("rot_g4", 64'(log_q[4].src), 64'd0);
    end
    chk("rot_pkt_done_pulses", 64'(pd_pulses), 64'd5);

    // Lock: req1 LONG_WRITE len 3 (5 flits) while req0 and req2 wait.
    log_q.delete();
    busy_cycles = 0;
    push_pkt(1, FMT_LONG_WRITE, 7'd3);
    push_pkt(0, FMT_SHORT_READ, 7'd0);
    push_pkt(2, FMT_SHORT_READ, 7'd0);
    drive();
    run_until_empty(50, "lock");
    chk("lock_count", 64'(log_q.size()), 64'd7);
    if (log_q.size() == 7) begin
      for (int k = 0; k < 5; k++) chk("lock_src1", 64'(log_q[k].src), 64'd1);
      chk("lock_next_req2", 64'(log_q[5].src), 64'd2);
      chk("lock_then_req0", 64'(log_q[6].src), 64'd0);
    end
    chk("lock_busy_cycles", 64'(busy_cycles), 64'd4);

    // Backpressure and a two-cycle bubble on a 3-flit MSG from req2.
    log_q.delete();
    push_pkt(2, FMT_MSG, 7'd2);
    push_pkt(0, FMT_SHORT_READ, 7'd0);
    drive();
    tick();
    out_ready = 1'b0; drive();
    tick();
    out_ready = 1'b1; hold[2] = 1; drive();
    tick();
    tick();
    hold[2] = 0; drive();
    run_until_empty(50, "bubble");
    chk("bub_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      chk("bub_src0", 64'(log_q[0].src), 64'd2);
      chk("bub_src1", 64'(log_q[1].src), 64'd2);
      chk("bub_src2", 64'(log_q[2].src), 64'd2);
      chk("bub_body1", 64'(log_q[1].f.payload[7:0]), 64'd1);
      chk("bub_body2", 64'(log_q[2].f.payload[7:0]), 64'd2);
      chk("bub_vc_pass", 64'(log_q[0].f.vc), 64'd2);
      chk("bub_then_req0", 64'(log_q[3].src), 64'd0);
    end

    // Zero-length fields: MEM_RESP len 0 is 129 flits, SHORT_WRITE len 0 is 17.
    log_q.delete();
    push_pkt(3, FMT_MEM_RESP, 7'd0);
    drive();
    run_until_empty(300, "memresp0");
    chk("memresp0_count", 64'(log_q.size()), 64'd129);
    if (log_q.size() > 0) chk("memresp0_last_src", 64'(log_q[log_q.size()-1].src), 64'd3);
    log_q.delete();
    push_pkt(0, FMT_SHORT_WRITE, 7'd0);
    drive();
    run_until_empty(100, "swrite0");
    chk("swrite0_count", 64'(log_q.size()), 64'd17);

    // Undefined format: single flit plus one fmt_err pulse.
    log_q.delete();
    fe_pulses = 0;
    push_pkt(1, 4'hF, 7'd5);
    drive();
    run_until_empty(20, "fmt_err");
    chk("fmt_err_count", 64'(log_q.size()), 64'd1);
    chk("fmt_err_pulses", 64'(fe_pulses), 64'd1);

    // Reset mid LONG_WRITE: lock drops at once and rr_ptr returns to 0.
    push_pkt(1, FMT_LONG_WRITE, 7'd3);
    drive();
    tick(); tick();
    chk("mid_busy_before", 64'(busy), 64'd1);
    n_rst = 1'b0;
    #1;
    chk("mid_busy_after_rst", 64'(busy), 64'd0);
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    tick();
    n_rst = 1'b1;
    log_q.delete();
    push_pkt(3, FMT_SHORT_READ, 7'd0);
    push_pkt(0, FMT_SHORT_READ, 7'd0);
    drive();
    run_until_empty(20, "post_rst");
    chk("post_rst_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("post_rst_first_req0", 64'(log_q[0].src), 64'd0);
      chk("post_rst_then_req3", 64'(log_q[1].src), 64'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
